// File: rtl/g_4strb4_if.sv
// Strobe sequencer bus: START/STOP requests in, AN..DN strobes and status out.
interface g_4strb4_if;
    logic START;
    logic STOP;
    logic AN;
    logic BN;
    logic CN;
    logic DN;
    logic BUSY;
    logic DONE;

    modport master (
        output START, STOP,
        input  AN, BN, CN, DN, BUSY, DONE
    );

    modport slave (
        input  START, STOP,
        output AN, BN, CN, DN, BUSY, DONE
    );
endinterface

// File: rtl/g_4strb4.sv
// Four-phase active-low strobe sequencer (A, B, C, D), registered outputs.
// Define G_4STRB4_GAP_EN to insert a one-cycle all-high gap between phases.
module g_4strb4 #(
    parameter int DWELL = 1
) (
    input  logic       CLK,
    input  logic       CD,
    g_4strb4_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, PA, PB, PC, PD, GAP
    } state_t;

    localparam logic [7:0] RELOAD = 8'(DWELL - 1);

    if (DWELL < 1 || DWELL > 255) begin : g_dwell_bad
        $error("g_4strb4: DWELL must be in 1..255");
    end

    state_t     state;
    state_t     state_n;
    state_t     nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       done_n;
`ifdef G_4STRB4_GAP_EN
    state_t     after;
    state_t     after_n;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        nxt     = IDLE;
`ifdef G_4STRB4_GAP_EN
        after_n = after;
`endif
        if (state == IDLE) begin
            if (bus.START && !bus.STOP) begin
                state_n = PA;
                cnt_n   = RELOAD;
            end
        end else if (bus.STOP) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
        end else if (state == GAP) begin
`ifdef G_4STRB4_GAP_EN
            state_n = after;
`endif
            cnt_n   = RELOAD;
        end else if (cnt != 8'd0) begin
            cnt_n = cnt - 8'd1;
        end else begin
            cnt_n = RELOAD;
            unique case (state)
                PA: nxt = PB;
                PB: nxt = PC;
                PC: nxt = PD;
                PD: begin
                    nxt    = IDLE;
                    done_n = 1'b1;
                end
                default: nxt = IDLE;
            endcase
`ifdef G_4STRB4_GAP_EN
            // Break-before-make: park in GAP, remembering the next phase.
            if (nxt != IDLE) begin
                state_n = GAP;
                after_n = nxt;
            end else begin
                state_n = IDLE;
            end
`else
            state_n = nxt;
`endif
        end
    end

    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            bus.AN   <= 1'b1;
            bus.BN   <= 1'b1;
            bus.CN   <= 1'b1;
            bus.DN   <= 1'b1;
            bus.BUSY <= 1'b0;
            bus.DONE <= 1'b0;
`ifdef G_4STRB4_GAP_EN
            after    <= IDLE;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bus.AN   <= (state_n != PA);
            bus.BN   <= (state_n != PB);
            bus.CN   <= (state_n != PC);
            bus.DN   <= (state_n != PD);
            bus.BUSY <= (state_n != IDLE);
            bus.DONE <= done_n;
`ifdef G_4STRB4_GAP_EN
            after    <= after_n;
`endif
        end
    end

endmodule
